mem_access_stage: RTL and testbench

- Pipeline MEM stage. Sits between the combinational EX stage and WB.
- Captures EX outputs and runs load/store transactions on a req/ack data-RAM port.
- Aligns and sign/zero-extends load data, then presents registered results to WB.
- Stalls the upstream pipeline while a RAM access is outstanding.

---
 rtl/mem_access_stage.sv | 186 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues EX loads/stores on a req/ack RAM port, aligns load data, registers WB results.
// Optional MEM_MISALIGN_CHECK_EN: faults misaligned half/word accesses instead of issuing them. DATA_W must be 32.
//
//   state | meaning
//   IDLE  | accept EX; ALU ops retire next edge, memops launch a RAM request
//   BUSY  | RAM request outstanding; upstream held until ram_ack
module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              mem_read_flag,
  input  logic              mem_write_flag,
  input  logic              mem_sign_flag,
  input  logic [3:0]        mem_sel,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              reg_write_en_in,
  input  logic [4:0]        reg_write_addr_in,
  input  logic [31:0]       pc_in,
  output logic              stall_req,
  output logic              mem_load_flag,
  output logic              ram_req,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_result,
  output logic              wb_reg_write_en,
  output logic [4:0]        wb_reg_write_addr,
  output logic [31:0]       wb_pc
`ifdef MEM_MISALIGN_CHECK_EN
  , output logic            misalign_fault
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nx;
  logic              take, memop, misalign;
  logic [6:0]        be_wide;
  logic [DATA_W-1:0] wdata_nx, load_sh, load_ext;

  logic              lat_load, lat_sign, lat_rwe;
  logic [3:0]        lat_sel;
  logic [1:0]        lat_off;
  logic [DATA_W-1:0] lat_result;
  logic [4:0]        lat_rwa;
  logic [31:0]       lat_pc;

  assign take    = ex_valid & ~flush;
  assign memop   = mem_read_flag | mem_write_flag;
  assign be_wide = {3'b000, mem_sel} << ex_result[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = ((mem_sel == 4'b0011) & ex_result[0]) |
                    ((mem_sel == 4'b1111) & (ex_result[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    wdata_nx = {4{mem_write_data[7:0]}};
    case (mem_sel)
      4'b1111: wdata_nx = mem_write_data;
      4'b0011: wdata_nx = {2{mem_write_data[15:0]}};
      default: wdata_nx = {4{mem_write_data[7:0]}};
    endcase
  end

  // Load lanes come from the latched offset; the word case ignores it.
  assign load_sh = ram_rdata >> {lat_off, 3'b000};
  always_comb begin
    load_ext = {{24{lat_sign & load_sh[7]}}, load_sh[7:0]};
    case (lat_sel)
      4'b1111: load_ext = ram_rdata;
      4'b0011: load_ext = {{16{lat_sign & load_sh[15]}}, load_sh[15:0]};
      default: load_ext = {{24{lat_sign & load_sh[7]}}, load_sh[7:0]};
    endcase
  end

  always_comb begin
    state_nx      = state;
    stall_req     = 1'b0;
    mem_load_flag = 1'b0;
    case (state)
      IDLE: begin
        if (take && memop && !misalign) begin
          stall_req = 1'b1;
          state_nx  = BUSY;
        end
      end
      BUSY: begin
        stall_req     = ~ram_ack;
        mem_load_flag = lat_load;
        if (ram_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      ram_req           <= 1'b0;
      ram_we            <= 1'b0;
      ram_be            <= '0;
      ram_addr          <= '0;
      ram_wdata         <= '0;
      wb_valid          <= 1'b0;
      wb_result         <= '0;
      wb_reg_write_en   <= 1'b0;
      wb_reg_write_addr <= '0;
      wb_pc             <= '0;
      lat_load          <= 1'b0;
      lat_sign          <= 1'b0;
      lat_rwe           <= 1'b0;
      lat_sel           <= '0;
      lat_off           <= '0;
      lat_result        <= '0;
      lat_rwa           <= '0;
      lat_pc            <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_fault    <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      wb_valid <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_fault <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (take && !memop) begin
            wb_valid          <= 1'b1;
            wb_result         <= ex_result;
            wb_reg_write_en   <= reg_write_en_in;
            wb_reg_write_addr <= reg_write_addr_in;
            wb_pc             <= pc_in;
          end else if (take && misalign) begin
            wb_valid          <= 1'b1;
            wb_result         <= ex_result;
            wb_reg_write_en   <= 1'b0;
            wb_reg_write_addr <= reg_write_addr_in;
            wb_pc             <= pc_in;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_fault    <= 1'b1;
`endif
          end else if (take) begin
            ram_req    <= 1'b1;
            ram_we     <= mem_write_flag;
            ram_be     <= be_wide[3:0];
            ram_addr   <= {ex_result[ADDR_W-1:2], 2'b00};
            ram_wdata  <= wdata_nx;
            lat_load   <= mem_read_flag & ~mem_write_flag;
            lat_sign   <= mem_sign_flag;
            lat_sel    <= mem_sel;
            lat_off    <= ex_result[1:0];
            lat_result <= ex_result;
            lat_rwe    <= reg_write_en_in;
            lat_rwa    <= reg_write_addr_in;
            lat_pc     <= pc_in;
          end
        end
        BUSY: begin
          if (ram_ack) begin
            ram_req           <= 1'b0;
            wb_valid          <= 1'b1;
            wb_result         <= lat_load ? load_ext : lat_result;
            wb_reg_write_en   <= lat_load & lat_rwe;
            wb_reg_write_addr <= lat_rwa;
            wb_pc             <= lat_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed + randomized bench for mem_access_stage; expected values come from an arithmetic lane model.
module tb_mem_access_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        flush = 0, ex_valid = 0, mem_read_flag = 0, mem_write_flag = 0, mem_sign_flag = 0;
  logic [3:0]  mem_sel = 4'b0001;
  logic [31:0] mem_write_data = 0, ex_result = 0, pc_in = 0;
  logic        reg_write_en_in = 0;
  logic [4:0]  reg_write_addr_in = 0;
  logic        stall_req, mem_load_flag, ram_req, ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr, ram_wdata;
  logic        ram_ack = 0;
  logic [31:0] ram_rdata = 0;
  logic        wb_valid, wb_reg_write_en;
  logic [31:0] wb_result, wb_pc;
  logic [4:0]  wb_reg_write_addr;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign_fault;
`endif

  int checks = 0, errors = 0;
  logic [31:0] last_wb = 0;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid),
    .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag), .mem_sign_flag(mem_sign_flag),
    .mem_sel(mem_sel), .mem_write_data(mem_write_data), .ex_result(ex_result),
    .reg_write_en_in(reg_write_en_in), .reg_write_addr_in(reg_write_addr_in), .pc_in(pc_in),
    .stall_req(stall_req), .mem_load_flag(mem_load_flag), .ram_req(ram_req), .ram_we(ram_we),
    .ram_be(ram_be), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ack(ram_ack),
    .ram_rdata(ram_rdata), .wb_valid(wb_valid), .wb_result(wb_result),
    .wb_reg_write_en(wb_reg_write_en), .wb_reg_write_addr(wb_reg_write_addr), .wb_pc(wb_pc)
`ifdef MEM_MISALIGN_CHECK_EN
    , .misalign_fault(misalign_fault)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: lanes from plain arithmetic on byte counts and offsets.
  function automatic logic [31:0] m_be(input int nbytes, input int off);
    int m = ((1 << nbytes) - 1) << off;
    return 32'(m & 15);
  endfunction

  function automatic logic [31:0] m_wdata(input int nbytes, input logic [31:0] wd);
    if (nbytes == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (nbytes == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input int nbytes, input int off, input logic sgn,
                                         input logic [31:0] rd);
    logic [31:0] v;
    if (nbytes == 4) return rd;
    v = (rd / (32'd1 << (8 * off))) % (32'd1 << (8 * nbytes));
    if (sgn && v >= (32'd1 << (8 * nbytes - 1))) v = v - (32'd1 << (8 * nbytes));
    return v;
  endfunction

  task automatic alu_op(input logic [31:0] res, input logic [4:0] rd, input logic we,
                        input logic [31:0] pc);
    @(negedge clk);
    ex_valid = 1; flush = 0; mem_read_flag = 0; mem_write_flag = 0;
    ex_result = res; reg_write_addr_in = rd; reg_write_en_in = we; pc_in = pc;
    ram_ack = 1'($urandom_range(0, 1));
    #1 chk("alu_stall", stall_req, 0);
    @(posedge clk); #1;
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_result", wb_result, res);
    chk("alu_wb_we", wb_reg_write_en, we);
    chk("alu_wb_addr", wb_reg_write_addr, rd);
    chk("alu_wb_pc", wb_pc, pc);
    chk("alu_ram_req", ram_req, 0);
    last_wb = res;
  endtask

  task automatic no_take(input logic use_flush);
    @(negedge clk);
    ex_valid = use_flush; flush = use_flush;
    mem_read_flag = 1'($urandom_range(0, 1)); mem_write_flag = 0;
    mem_sel = 4'b1111; ex_result = $urandom & 32'hFFFF_FFFC;
    ram_ack = 1'($urandom_range(0, 1));
    #1 chk("idle_stall", stall_req, 0);
    @(posedge clk); #1;
    chk("idle_wb_valid", wb_valid, 0);
    chk("idle_ram_req", ram_req, 0);
    chk("idle_wb_hold", wb_result, last_wb);
`ifdef MEM_MISALIGN_CHECK_EN
    chk("idle_fault_low", misalign_fault, 0);
`endif
  endtask

  task automatic mem_op(input logic rd_f, input logic wr_f, input logic sgn, input int nbytes,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                        input logic [4:0] rdst, input logic we, input logic [31:0] pc,
                        input int wait_n);
    int off = int'(addr[1:0]);
    logic is_load = rd_f & ~wr_f;
    logic [31:0] exp_wb = is_load ? m_load(nbytes, off, sgn, rdat) : addr;
    @(negedge clk);
    ex_valid = 1; flush = 0; mem_read_flag = rd_f; mem_write_flag = wr_f; mem_sign_flag = sgn;
    mem_sel = 4'(((1 << nbytes) - 1)); ex_result = addr; mem_write_data = wd;
    reg_write_addr_in = rdst; reg_write_en_in = we; pc_in = pc; ram_ack = 0; ram_rdata = rdat;
    #1 chk("req_stall", stall_req, 1);
    @(posedge clk); #1;
    chk("req_ram_req", ram_req, 1);
    chk("req_ram_we", ram_we, wr_f);
    chk("req_ram_be", ram_be, m_be(nbytes, off));
    chk("req_ram_addr", ram_addr, addr & 32'hFFFF_FFFC);
    chk("req_ram_wdata", ram_wdata, m_wdata(nbytes, wd));
    chk("req_wb_valid", wb_valid, 0);
    for (int k = 0; k <= wait_n; k++) begin
      @(negedge clk);
      ram_ack = (k == wait_n);
      flush = 1'($urandom_range(0, 1));
      #1;
      chk("busy_stall", stall_req, (k != wait_n));
      chk("busy_load_flag", mem_load_flag, is_load);
      @(posedge clk); #1;
      if (k < wait_n) begin
        chk("busy_ram_req", ram_req, 1);
        chk("busy_ram_addr", ram_addr, addr & 32'hFFFF_FFFC);
        chk("busy_wb_valid", wb_valid, 0);
      end else begin
        chk("done_wb_valid", wb_valid, 1);
        chk("done_wb_result", wb_result, exp_wb);
        chk("done_wb_we", wb_reg_write_en, is_load & we);
        chk("done_wb_addr", wb_reg_write_addr, rdst);
        chk("done_wb_pc", wb_pc, pc);
        chk("done_ram_req", ram_req, 0);
      end
    end
    last_wb = exp_wb;
  endtask

  initial begin
    #2;
    chk("rst_ram_req", ram_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_ram_be", ram_be, 0);
    chk("rst_wb_result", wb_result, 0);
    @(negedge clk); rst_n = 1;

    alu_op(32'h1234, 5'd5, 1'b1, 32'h100);
    mem_op(1, 0, 1, 1, 32'h103, 32'h0, 32'h80FF_FFFF, 5'd7, 1, 32'h104, 3);
    mem_op(1, 0, 0, 2, 32'h202, 32'h0, 32'hBEEF_0000, 5'd8, 1, 32'h108, 0);
    mem_op(0, 1, 0, 1, 32'h301, 32'hAB, 32'h0, 5'd9, 1, 32'h10C, 1);
    mem_op(1, 1, 1, 4, 32'h500, 32'hCAFE_F00D, 32'h1111_2222, 5'd3, 1, 32'h110, 2);
    no_take(1'b1);
    no_take(1'b0);

`ifdef MEM_MISALIGN_CHECK_EN
    @(negedge clk);
    ex_valid = 1; flush = 0; mem_read_flag = 1; mem_write_flag = 0; mem_sel = 4'b1111;
    ex_result = 32'h402; reg_write_en_in = 1; reg_write_addr_in = 5'd4; pc_in = 32'h114;
    #1 chk("mis_stall", stall_req, 0);
    @(posedge clk); #1;
    chk("mis_ram_req", ram_req, 0);
    chk("mis_fault", misalign_fault, 1);
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_wb_result", wb_result, 32'h402);
    chk("mis_wb_we", wb_reg_write_en, 0);
    last_wb = 32'h402;
    no_take(1'b0);
`endif

    // Async reset while a request is outstanding.
    @(negedge clk);
    ex_valid = 1; flush = 0; mem_read_flag = 1; mem_write_flag = 0; mem_sel = 4'b1111;
    ex_result = 32'h600; ram_ack = 0;
    @(posedge clk); #1 chk("prerst_ram_req", ram_req, 1);
    @(negedge clk); ex_valid = 0;
    #1 rst_n = 0;
    #1;
    chk("arst_ram_req", ram_req, 0);
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_stall", stall_req, 0);
    chk("arst_ram_addr", ram_addr, 0);
    #1 rst_n = 1;
    last_wb = 0;
    no_take(1'b0);
    alu_op(32'hDEAD_BEEF, 5'd31, 1'b0, 32'h200);

    for (int i = 0; i < 40; i++) begin
      int kind = int'($urandom_range(0, 3));
      int nb = (kind == 0) ? 1 : 1 << $urandom_range(0, 2);
      logic [31:0] a = $urandom;
`ifdef MEM_MISALIGN_CHECK_EN
      a = a & ~(32'(nb) - 32'd1);
`endif
      case (kind)
        0: alu_op($urandom, 5'($urandom), 1'($urandom), $urandom);
        1: no_take(1'($urandom));
        2: mem_op(1, 0, 1'($urandom), nb, a, $urandom, $urandom, 5'($urandom), 1'($urandom),
                  $urandom, int'($urandom_range(0, 3)));
        default: mem_op(1'($urandom), 1, 0, nb, a, $urandom, $urandom, 5'($urandom), 1,
                        $urandom, int'($urandom_range(0, 3)));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
